// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between three requesters:
//   0 = instruction fetch, 1 = load/store, 2 = I/O / debug.
// Grants round-robin. A grant is held until the memory acknowledges (or the
// owner drops its request), then passes straight to the next pending
// requester with no idle cycle in between. Also drives the 2-bit select of
// the 3-to-1 address/data muxer in front of the port
// (00=req0, 01=req1, 10=req2, 11=idle, bus driven to zero).
//
// Build option:
//   ARB_TIMEOUT_EN  when defined, a grant held for TIMEOUT cycles without
//                   mem_ack is forcibly released and timeout_err pulses for
//                   one cycle. When undefined, a grant is held indefinitely
//                   and timeout_err is tied to 0.
//
// Parameters:
//   TIMEOUT  max OWN cycles without mem_ack (ARB_TIMEOUT_EN builds only)
//   CNT_W    hold counter width, 2**CNT_W must exceed TIMEOUT
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   req[2:0]     in   level request per requester, held until its ack
//   mem_ack      in   1-cycle pulse: memory finished the current transfer
//   grant[2:0]   out  registered one-hot grant, 000 when idle
//   sel[1:0]     out  registered muxer select, 11 when idle
//   ack[2:0]     out  combinational, grant & {3{mem_ack}}
//   busy         out  registered, 1 while a grant is held
//   timeout_err  out  registered 1-cycle pulse on forced release
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic       mem_ack,
   output logic [2:0] grant,
   output logic [1:0] sel,
   output logic [2:0] ack,
   output logic       busy,
   output logic       timeout_err
);

   // Configuration sanity: the hold counter must be able to represent TIMEOUT.
   if ((1 << CNT_W) <= TIMEOUT) begin : g_bad_cfg
      $error("mem_port_arbiter: 2**CNT_W must be greater than TIMEOUT");
   end

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_e;

   localparam logic [1:0] SEL_IDLE = 2'b11;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------

   // Round-robin successor. The pointer never holds 3, but if it ever does it
   // is treated as 0, so 3 maps to 1 like 0 does.
   function automatic logic [1:0] inc_mod3(input logic [1:0] idx);
      logic [1:0] nxt;
      case (idx)
         2'd0:    nxt = 2'd1;
         2'd1:    nxt = 2'd2;
         2'd2:    nxt = 2'd0;
         default: nxt = 2'd1;
      endcase
      return nxt;
   endfunction

   // Search order start, start+1, start+2 (mod 3). Returns {found, winner}.
   function automatic logic [2:0] rr_pick(input logic [2:0] mask,
                                          input logic [1:0] start);
      logic [1:0] idx;
      logic [2:0] res;
      idx = (start == 2'd3) ? 2'd0 : start;
      res = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (!res[2] && mask[idx]) begin
            res = {1'b1, idx};
         end
         idx = inc_mod3(idx);
      end
      return res;
   endfunction

   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      logic [2:0] oh;
      case (idx)
         2'd0:    oh = 3'b001;
         2'd1:    oh = 3'b010;
         2'd2:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e     state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [1:0] ptr_q,   ptr_d;
   logic [2:0] grant_q, grant_d;
   logic [1:0] sel_q,   sel_d;
   logic       busy_q,  busy_d;

   logic [2:0] idle_win;     // {found, winner} searching all requests from ptr
   logic [1:0] rel_ptr;      // pointer after the current owner releases
   logic [2:0] rel_win;      // {found, winner} excluding the releasing owner
   logic       owner_req;    // current owner still requesting
   logic       timeout_hit;  // forced release this cycle
   logic       release_own;  // owner gives up the port at the next edge
   logic       enter_own;    // a new grant starts at the next edge

   assign owner_req = |(req & onehot3(owner_q));
   assign idle_win  = rr_pick(req, ptr_q);
   assign rel_ptr   = inc_mod3(owner_q);
   // The releasing owner is masked out so that a requester re-asserting right
   // after its own ack cannot immediately win again over other pending work.
   assign rel_win   = rr_pick(req & ~onehot3(owner_q), rel_ptr);

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_err_q;

   // The cycle in which the count reaches TIMEOUT is the last one the grant
   // is held, so the owner sees exactly TIMEOUT grant cycles.
   assign timeout_hit = (state_q == ST_OWN) && !mem_ack &&
                        (int'(cnt_q) >= TIMEOUT - 1);
`else
   assign timeout_hit = 1'b0;
`endif

   // Normal completion, abort (owner dropped req) and forced release all hand
   // off identically; mem_ack together with a dropped req is a completion.
   assign release_own = (state_q == ST_OWN) &&
                        (mem_ack || !owner_req || timeout_hit);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned; an unassigned path in always_comb would infer a latch.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      enter_own = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (idle_win[2]) begin
               state_d   = ST_OWN;
               owner_d   = idle_win[1:0];
               enter_own = 1'b1;
            end
         end
         ST_OWN: begin
            if (release_own) begin
               ptr_d = rel_ptr;
               if (rel_win[2]) begin
                  owner_d   = rel_win[1:0];
                  enter_own = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are a pure function of the next state, registered below.
      if (state_d == ST_OWN) begin
         grant_d = onehot3(owner_d);
         sel_d   = owner_d;
         busy_d  = 1'b1;
      end else begin
         grant_d = 3'b000;
         sel_d   = SEL_IDLE;
         busy_d  = 1'b0;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Hold counter: cleared on every entry to OWN (including hand-offs),
   // counts OWN cycles without mem_ack, saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (enter_own) begin
         cnt_d = '0;
      end else if ((state_q == ST_OWN) && !mem_ack && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= 2'd0;
         ptr_q   <= 2'd0;
         grant_q <= 3'b000;
         sel_q   <= SEL_IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_hit;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign grant = grant_q;
   assign sel   = sel_q;
   assign busy  = busy_q;
   // grant is 000 in IDLE and during reset, so a stray mem_ack produces no ack.
   assign ack   = grant_q & {3{mem_ack}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed stimulus with hand-computed expectations. Each stimulus step drives
// the inputs for one clock cycle and pushes the outputs expected during that
// cycle into a queue; an independent monitor samples the DUT on the falling
// edge and pops/compares one entry per cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 5;

   logic       clk;
   logic       rst_n;
   logic [2:0] req;
   logic       mem_ack;
   logic [2:0] grant;
   logic [1:0] sel;
   logic [2:0] ack;
   logic       busy;
   logic       timeout_err;

   mem_port_arbiter #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .mem_ack     (mem_ack),
      .grant       (grant),
      .sel         (sel),
      .ack         (ack),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] grant;
      logic [1:0] sel;
      logic [2:0] ack;
      logic       busy;
      logic       terr;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input string field,
                        input logic [7:0] actual, input logic [7:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s.%s: got %b expected %b", name, field, actual, expected);
      end
   endtask

   // Monitor: one expected record per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check(e.name, "grant", {5'd0, grant},       {5'd0, e.grant});
         check(e.name, "sel",   {6'd0, sel},         {6'd0, e.sel});
         check(e.name, "ack",   {5'd0, ack},         {5'd0, e.ack});
         check(e.name, "busy",  {7'd0, busy},        {7'd0, e.busy});
         check(e.name, "terr",  {7'd0, timeout_err}, {7'd0, e.terr});
      end
   end

   // Drive one cycle of inputs and queue the outputs expected in that cycle.
   task automatic step(input logic r, input logic [2:0] rq, input logic ma,
                       input logic [2:0] eg, input logic [1:0] es,
                       input logic [2:0] ea, input logic eb, input logic et,
                       input string name);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n   = r;
      req     = rq;
      mem_ack = ma;
      e.grant = eg;
      e.sel   = es;
      e.ack   = ea;
      e.busy  = eb;
      e.terr  = et;
      e.name  = name;
      exp_q.push_back(e);
   endtask

   initial begin
      rst_n   = 1'b0;
      req     = 3'b000;
      mem_ack = 1'b0;

      //    rst  req     ack   grant   sel    ack     busy  terr
      // Reset state, requests and acks ignored while in reset
      step(0, 3'b000, 0,   3'b000, 2'b11, 3'b000, 0, 0, "reset");
      step(0, 3'b111, 1,   3'b000, 2'b11, 3'b000, 0, 0, "reset_hold");
      step(1, 3'b000, 0,   3'b000, 2'b11, 3'b000, 0, 0, "idle_after_reset");
      // Spurious ack while idle
      step(1, 3'b000, 1,   3'b000, 2'b11, 3'b000, 0, 0, "spurious_ack");
      step(1, 3'b000, 0,   3'b000, 2'b11, 3'b000, 0, 0, "stay_idle");
      // Single requester: grant one cycle after req, ack at cycle 3, idle at 4
      step(1, 3'b001, 0,   3'b000, 2'b11, 3'b000, 0, 0, "single_c0");
      step(1, 3'b001, 0,   3'b001, 2'b00, 3'b000, 1, 0, "single_c1");
      step(1, 3'b001, 0,   3'b001, 2'b00, 3'b000, 1, 0, "single_c2");
      step(1, 3'b001, 1,   3'b001, 2'b00, 3'b001, 1, 0, "single_ack");
      step(1, 3'b000, 0,   3'b000, 2'b11, 3'b000, 0, 0, "single_idle");
      // Reset to bring ptr back to 0, then round robin with req=111
      step(0, 3'b000, 0,   3'b000, 2'b11, 3'b000, 0, 0, "reset2");
      step(1, 3'b111, 0,   3'b000, 2'b11, 3'b000, 0, 0, "rr_req");
      step(1, 3'b111, 0,   3'b001, 2'b00, 3'b000, 1, 0, "rr_g0");
      step(1, 3'b111, 1,   3'b001, 2'b00, 3'b001, 1, 0, "rr_ack0");
      step(1, 3'b111, 0,   3'b010, 2'b01, 3'b000, 1, 0, "rr_g1");
      step(1, 3'b111, 1,   3'b010, 2'b01, 3'b010, 1, 0, "rr_ack1");
      step(1, 3'b111, 0,   3'b100, 2'b10, 3'b000, 1, 0, "rr_g2");
      step(1, 3'b111, 1,   3'b100, 2'b10, 3'b100, 1, 0, "rr_ack2");
      // Wrap to requester 0, then abort: req[0] drops with req[1] pending
      step(1, 3'b011, 0,   3'b001, 2'b00, 3'b000, 1, 0, "rr_wrap");
      step(1, 3'b010, 0,   3'b001, 2'b00, 3'b000, 1, 0, "abort_drop");
      step(1, 3'b011, 0,   3'b010, 2'b01, 3'b000, 1, 0, "abort_handoff");
      // req1 acked with ptr->2: only req0 pending, it wins directly
      step(1, 3'b011, 1,   3'b010, 2'b01, 3'b010, 1, 0, "fair_ack1");
      step(1, 3'b001, 0,   3'b001, 2'b00, 3'b000, 1, 0, "fair_own0");
      // Non-owner request changes have no effect during OWN
      step(1, 3'b111, 0,   3'b001, 2'b00, 3'b000, 1, 0, "nonowner_a");
      step(1, 3'b101, 0,   3'b001, 2'b00, 3'b000, 1, 0, "nonowner_b");
      // Ack and req drop together = completion; ptr->1, req2 wins
      step(1, 3'b100, 1,   3'b001, 2'b00, 3'b001, 1, 0, "ack_and_drop");
      // Sole requester re-wins via one IDLE cycle
      step(1, 3'b100, 1,   3'b100, 2'b10, 3'b100, 1, 0, "own2_ack");
      step(1, 3'b100, 0,   3'b000, 2'b11, 3'b000, 0, 0, "rereq_idle");
      step(1, 3'b100, 0,   3'b100, 2'b10, 3'b000, 1, 0, "rereq_win");

`ifdef ARB_TIMEOUT_EN
      // rereq_win was OWN cycle 1; 15 more grant cycles make 16 in total.
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         step(1, 3'b100, 0, 3'b100, 2'b10, 3'b000, 1, 0, "timeout_hold");
      end
      step(1, 3'b100, 0,   3'b000, 2'b11, 3'b000, 0, 1, "timeout_release");
      step(1, 3'b100, 0,   3'b100, 2'b10, 3'b000, 1, 0, "timeout_rewin");
`else
      // Without forced release the grant persists.
      for (int i = 0; i < 100; i++) begin
         step(1, 3'b100, 0, 3'b100, 2'b10, 3'b000, 1, 0, "hold_forever");
      end
`endif

      // Reset asserted mid-transfer with mem_ack high: outputs clear at once
      step(0, 3'b100, 1,   3'b000, 2'b11, 3'b000, 0, 0, "reset_mid_own");
      step(0, 3'b000, 0,   3'b000, 2'b11, 3'b000, 0, 0, "reset_mid_hold");

      // Drain the scoreboard with a bounded wait
      begin
         int budget;
         budget = 10;
         while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
         end
         n_checks++;
         if (exp_q.size() == 0) begin
            n_pass++;
         end else begin
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
